// File: rtl/dma_desc_mem_arb_if.sv
// Signal bundle between the descriptor fetch/writeback requesters, the shared
// descriptor-memory slave and the arbiter that sits between them.
interface dma_desc_mem_arb_if;
  // fetch port (burst read)
  logic        fetch_read_i;
  logic [3:0]  fetch_bcount_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_waitrequest_o;
  logic [31:0] fetch_rddata_o;
  logic        fetch_readdatavalid_o;
  // writeback port (burst write)
  logic        wb_write_i;
  logic [3:0]  wb_bcount_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_wrdata_i;
  logic        wb_waitrequest_o;
  // shared descriptor-memory port
  logic        avm_read_o;
  logic        avm_write_o;
  logic [31:0] avm_addr_o;
  logic [3:0]  avm_bcount_o;
  logic [31:0] avm_wrdata_o;
  logic        avm_waitrequest_i;
  logic [31:0] avm_rddata_i;
  logic        avm_readdatavalid_i;
  // status
  logic        busy_o;
  logic        spurious_rdv_o;

  // The arbiter itself.
  modport slave (
    input  fetch_read_i, fetch_bcount_i, fetch_addr_i,
    output fetch_waitrequest_o, fetch_rddata_o, fetch_readdatavalid_o,
    input  wb_write_i, wb_bcount_i, wb_addr_i, wb_wrdata_i,
    output wb_waitrequest_o,
    output avm_read_o, avm_write_o, avm_addr_o, avm_bcount_o, avm_wrdata_o,
    input  avm_waitrequest_i, avm_rddata_i, avm_readdatavalid_i,
    output busy_o, spurious_rdv_o
  );

  // The environment: both requesters plus the memory slave.
  modport master (
    output fetch_read_i, fetch_bcount_i, fetch_addr_i,
    input  fetch_waitrequest_o, fetch_rddata_o, fetch_readdatavalid_o,
    output wb_write_i, wb_bcount_i, wb_addr_i, wb_wrdata_i,
    input  wb_waitrequest_o,
    input  avm_read_o, avm_write_o, avm_addr_o, avm_bcount_o, avm_wrdata_o,
    output avm_waitrequest_i, avm_rddata_i, avm_readdatavalid_i,
    input  busy_o, spurious_rdv_o
  );
endinterface

// File: rtl/dma_desc_mem_arb.sv
// Two-port burst arbiter: descriptor fetch (reads) and writeback (writes) share
// one descriptor-memory port; a granted burst owns the port until it completes.
module dma_desc_mem_arb #(
  parameter bit FIXED_PRIO = 1'b0  // 0: round-robin ties, 1: fetch wins ties
) (
  input logic                clk,
  input logic                reset_n,
  dma_desc_mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    RD_DATA  = 2'd2,
    WR_BEATS = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_WB    = 1'b0,
    GRANT_FETCH = 1'b1
  } grant_t;

  state_t      state, state_nxt;
  grant_t      last_grant;
  logic [31:0] addr_q;
  logic [3:0]  bcount_q;
  logic [3:0]  beat_cnt;
  logic        spurious_q;

  logic        fetch_wins;
  logic        beat_done;
  logic        last_beat;

  // Fetch takes a tie when priority is fixed or when writeback had the last grant.
  assign fetch_wins = bus.fetch_read_i &&
                      (!bus.wb_write_i || FIXED_PRIO || (last_grant == GRANT_WB));
  assign last_beat  = ((beat_cnt + 4'd1) == bcount_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output and next-state term gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt                 = state;
    beat_done                 = 1'b0;
    bus.avm_read_o            = 1'b0;
    bus.avm_write_o           = 1'b0;
    bus.avm_wrdata_o          = '0;
    bus.fetch_waitrequest_o   = 1'b1;
    bus.wb_waitrequest_o      = 1'b1;
    bus.fetch_readdatavalid_o = 1'b0;

    unique case (state)
      IDLE: begin
        if (fetch_wins)          state_nxt = RD_CMD;
        else if (bus.wb_write_i) state_nxt = WR_BEATS;
      end
      RD_CMD: begin
        bus.avm_read_o          = 1'b1;
        bus.fetch_waitrequest_o = bus.avm_waitrequest_i;
        if (!bus.avm_waitrequest_i) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.fetch_readdatavalid_o = bus.avm_readdatavalid_i;
        beat_done                 = bus.avm_readdatavalid_i;
        if (beat_done && last_beat) state_nxt = IDLE;
      end
      WR_BEATS: begin
        bus.avm_write_o      = bus.wb_write_i;
        bus.avm_wrdata_o     = bus.wb_wrdata_i;
        bus.wb_waitrequest_o = bus.avm_waitrequest_i;
        // A deasserted write simply stalls the burst here.
        beat_done            = bus.wb_write_i && !bus.avm_waitrequest_i;
        if (beat_done && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, latched command fields, beat counter and sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_WB;
      addr_q     <= '0;
      bcount_q   <= '0;
      beat_cnt   <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (fetch_wins) begin
          addr_q     <= bus.fetch_addr_i;
          bcount_q   <= (bus.fetch_bcount_i == 4'd0) ? 4'd1 : bus.fetch_bcount_i;
          last_grant <= GRANT_FETCH;
        end else if (bus.wb_write_i) begin
          addr_q     <= bus.wb_addr_i;
          bcount_q   <= (bus.wb_bcount_i == 4'd0) ? 4'd1 : bus.wb_bcount_i;
          last_grant <= GRANT_WB;
        end
      end else if (beat_done) begin
        beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
      end

      // Read data nobody asked for is dropped but remembered.
      if (bus.avm_readdatavalid_i && (state != RD_DATA)) spurious_q <= 1'b1;
    end
  end

  assign bus.avm_addr_o     = addr_q;
  assign bus.avm_bcount_o   = bcount_q;
  assign bus.fetch_rddata_o = bus.avm_rddata_i;
  assign bus.busy_o         = (state != IDLE);
  assign bus.spurious_rdv_o = spurious_q;

endmodule
